reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
Shares the register bank's single write port and its dedicated $mem load port among several writeback requesters, e.g. core writeback, $ra save on call, and debug loader. It arbitrates round-robin and registers the winning write onto the bank's write-control signals. It also serialises bank-A index-1 writes against memory loads and silently drops writes to $zero. It sits between the core's writeback sources and the register bank.

Parameters:
NUM_REQ, 3, number of register-write requesters (2..4)
RR_W, 2, width of round-robin pointer (ceil log2 NUM_REQ)

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
reqValid  in  NUM_REQ  per-requester write request
reqBank  in  NUM_REQ  per-requester bank select: 0 = bank A ($zero,$mem,$t0,$t1), 1 = bank B ($t2,$t3,$t4,$ra)
reqAddr  in  2*NUM_REQ  packed register index, requester i at [2i+1:2i]
reqData  in  8*NUM_REQ  packed write data, requester i at [8i+7:8i]
reqReady  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
memValid  in  1  memory-load write request to $mem
memData  in  8  load data
memReady  out  1  grant for memory load
writeReg  out  2  bank write index
writeData  out  8  bank write data
RegWrite  out  1  bank write strobe
isSendType0  out  1  bank select to register bank (1 = bank B)
memWrite  out  8  $mem load data
RegMemWrite  out  1  $mem write strobe
zeroDrop  out  1  one-cycle pulse: accepted write to bank A index 0 discarded

Behaviour:
- One clock domain. Reset is asynchronous and active-low: resetN low immediately clears all registered outputs and internal state.
- Reset values: writeReg=0, writeData=0, RegWrite=0, isSendType0=0, memWrite=0, RegMemWrite=0, zeroDrop=0, rrPtr=0, memYield=0. reqReady and memReady are combinational and 0 while resetN is low.
- Arbitration is combinational within cycle N. Requester search starts at rrPtr and wraps modulo NUM_REQ. The first requester with reqValid=1 is the candidate.
- Conflict: a candidate conflicts when it targets bank A index 1 while memValid=1.
  - memYield=0: memory wins; the candidate is not granted and rrPtr holds.
  - memYield=1: the candidate wins; memReady=0 this cycle.
  - memYield toggles on every conflict cycle, so neither side starves.
- With no conflict, the candidate and the memory port are both granted in the same cycle.
- On a requester grant, rrPtr <= granted index + 1, wrapping modulo NUM_REQ.
- Latency: a transfer accepted in cycle N drives writeReg/writeData/isSendType0 and RegWrite=1 in cycle N+1, and commits on the edge ending cycle N+1. A memory load accepted in cycle N drives RegMemWrite=1 and memWrite in cycle N+1.
- Strobes are single-cycle. With no grant in cycle N, RegWrite=0 and RegMemWrite=0 in cycle N+1. Data outputs hold their last values.
- $zero guard: an accepted write with reqBank=0 and reqAddr=0 is handshaken normally (reqReady=1), but RegWrite stays 0 in N+1 and zeroDrop=1 in N+1. The rrPtr update still applies.
- At most one bank write and one $mem write per cycle. Back-to-back grants are allowed every cycle, giving full throughput.
- Requesters must hold valid, bank, address and data stable until ready; this is a protocol rule, not checked.
- Reset mid-operation: an in-flight registered write is discarded, with no strobe after reset asserts. The arbiter restarts from rrPtr=0.

Decomposition:
- Shared package nanorisc_pkg holds:
  - bank select constants BANK_A=0 and BANK_B=1
  - register indices REG_ZERO=0, REG_MEM=1, REG_RA=3
  - data width DATA_W=8
- One sub-module, rr_pick: combinational round-robin priority picker. It takes the valid vector and pointer and returns a one-hot grant and an index. It is reusable by other arbiters.

Test Plan:
- Single requester 0 writes bank B index 3 with 0xA5 in cycle 0 -> reqReady[0]=1 in cycle 0; cycle 1 shows RegWrite=1, isSendType0=1, writeReg=3, writeData=0xA5; cycle 2 shows RegWrite=0.
- All 3 requesters valid continuously for 6 cycles -> grants in order 0,1,2,0,1,2, one per cycle, no gaps.
- Requester 1 targets A1 with 0x11 while memValid with 0x22, held 2 cycles:
  - cycle 0: memReady=1, reqReady=0.
  - cycle 1: reqReady[1]=1, memReady=0.
  - Bank sees RegMemWrite with 0x22, then RegWrite to A1 with 0x11.
- Requester 2 writes A0 with 0xFF -> handshake completes; next cycle RegWrite=0 and zeroDrop=1.
- Requester 0 writes A2 with 0x07 concurrently with memValid 0x3C -> both granted in the same cycle; next cycle RegWrite=1 and RegMemWrite=1 together.
- Grant accepted, then resetN pulsed low mid-cycle before the next edge -> RegWrite=0 immediately, no strobe after release; the next grant starts from requester 0.

Source files
------------

// File: rtl/nanorisc_pkg.sv
// Shared constants for the nanorisc register bank.
// Holds bank selects, register indices and the data width.
package nanorisc_pkg;

    localparam int DATA_W = 8;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    localparam logic [1:0] REG_ZERO = 2'd0;
    localparam logic [1:0] REG_MEM  = 2'd1;
    localparam logic [1:0] REG_RA   = 2'd3;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid requester at or after ptr, wrapping.
// Returns a one-hot grant, the winner's index, and whether any requester was valid.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank write port and the $mem load port.
// Serialises bank-A $mem writes against loads and silently drops writes to $zero.
module reg_write_arbiter
    import nanorisc_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int RR_W    = 2
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ-1:0]        reqBank,
    input  logic [2*NUM_REQ-1:0]      reqAddr,
    input  logic [DATA_W*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      memValid,
    input  logic [DATA_W-1:0]         memData,
    output logic                      memReady,
    output logic [1:0]                writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic                      RegWrite,
    output logic                      isSendType0,
    output logic [DATA_W-1:0]         memWrite,
    output logic                      RegMemWrite,
    output logic                      zeroDrop
);

    logic [RR_W-1:0]    rr_ptr;
    logic               mem_yield;
    logic [NUM_REQ-1:0] cand_onehot;
    logic [RR_W-1:0]    cand_idx;
    logic               cand_any;
    logic               cand_bank;
    logic [1:0]         cand_addr;
    data_t              cand_data;
    logic               conflict;
    logic               zero_hit;
    logic               req_grant;
    logic               mem_grant;
    logic [RR_W-1:0]    next_ptr;

    rr_pick #(.N(NUM_REQ), .W(RR_W)) u_pick (
        .valid (reqValid),
        .ptr   (rr_ptr),
        .grant (cand_onehot),
        .idx   (cand_idx),
        .any   (cand_any)
    );

    assign cand_bank = reqBank[cand_idx];
    assign cand_addr = reqAddr[2*int'(cand_idx) +: 2];
    assign cand_data = reqData[DATA_W*int'(cand_idx) +: DATA_W];

    // The load port only ever writes $mem, so only a bank-A index-1 candidate collides with it.
    assign conflict  = cand_any && (cand_bank == BANK_A) && (cand_addr == REG_MEM) && memValid;
    assign zero_hit  = (cand_bank == BANK_A) && (cand_addr == REG_ZERO);
    assign req_grant = resetN && cand_any && (!conflict || mem_yield);
    assign mem_grant = resetN && memValid && !(conflict && mem_yield);
    assign next_ptr  = (cand_idx == RR_W'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;

    assign reqReady  = req_grant ? cand_onehot : '0;
    assign memReady  = mem_grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rr_ptr      <= '0;
            mem_yield   <= 1'b0;
            writeReg    <= '0;
            writeData   <= '0;
            isSendType0 <= 1'b0;
            RegWrite    <= 1'b0;
            memWrite    <= '0;
            RegMemWrite <= 1'b0;
            zeroDrop    <= 1'b0;
        end else begin
            RegWrite    <= req_grant && !zero_hit;
            zeroDrop    <= req_grant && zero_hit;
            RegMemWrite <= mem_grant;
            if (req_grant) rr_ptr <= next_ptr;
            // A dropped $zero write leaves the visible write bus untouched.
            if (req_grant && !zero_hit) begin
                writeReg    <= cand_addr;
                writeData   <= cand_data;
                isSendType0 <= (cand_bank == BANK_B);
            end
            if (mem_grant) memWrite <= memData;
            if (conflict) mem_yield <= ~mem_yield;
        end
    end

endmodule
